// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - shared op/state encodings and NZP constants for alu_pipe
package alu_pipe_pkg;

  typedef enum logic [2:0] {
    ALU_PASSA = 3'b000,
    ALU_ADD   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_NOT   = 3'b011,
    ALU_SUB   = 3'b100,
    ALU_MUL   = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  localparam logic [2:0] NZP_N = 3'b100;
  localparam logic [2:0] NZP_Z = 3'b010;
  localparam logic [2:0] NZP_P = 3'b001;

endpackage

// File: rtl/alu_pipe_mul.sv
// rtl/alu_pipe_mul.sv - iterative shift-add multiplier, one multiplier bit per cycle
module alu_pipe_mul #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  // prod is the accumulator after the current step, so the owner can capture
  // the final product on the same edge that retires the last iteration.
  assign prod = acc + (mplier[0] ? mcand : '0);
  assign done = (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
    end else if (cnt != '0) begin
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked LC-3 ALU with NZP/overflow flags; ALU_MUL_EN adds iterative MUL
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             imm_sel,
  input  logic [IMM_W-1:0] imm,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       nzp,
  output logic             ovf,
  output logic             illegal
);

  import alu_pipe_pkg::*;

  state_e           state;
  logic             accept;
  logic             is_mul;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;

  function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1])   return NZP_N;
    else if (v == '0) return NZP_Z;
    else              return NZP_P;
  endfunction

  assign in_ready  = (state == ST_IDLE) | ((state == ST_HOLD) & out_ready);
  assign out_valid = (state == ST_HOLD);
  assign accept    = in_valid & in_ready;
  assign b_op      = imm_sel ? {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm} : rb;
  assign sum       = ra + b_op;
  assign diff      = ra - b_op;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (op)
      ALU_PASSA: alu_res = ra;
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (ra[WIDTH-1] == b_op[WIDTH-1]) & (sum[WIDTH-1] != ra[WIDTH-1]);
      end
      ALU_AND:   alu_res = ra & b_op;
      ALU_NOT:   alu_res = ~ra;
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (ra[WIDTH-1] != b_op[WIDTH-1]) & (diff[WIDTH-1] != ra[WIDTH-1]);
      end
`ifdef ALU_MUL_EN
      ALU_MUL:   alu_ill = 1'b0;
`endif
      default:   alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  assign is_mul = (op == ALU_MUL);

  alu_pipe_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept & is_mul),
    .a     (ra),
    .b     (b_op),
    .done  (mul_done),
    .prod  (mul_prod)
  );
`else
  assign is_mul = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      result  <= '0;
      nzp     <= NZP_Z;
      ovf     <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            if (is_mul) begin
              state <= ST_BUSY;
            end else begin
              state   <= ST_HOLD;
              result  <= alu_res;
              nzp     <= nzp_of(alu_res);
              ovf     <= alu_ovf;
              illegal <= alu_ill;
            end
          end else if ((state == ST_HOLD) && out_ready) begin
            state <= ST_IDLE;
          end
        end
`ifdef ALU_MUL_EN
        ST_BUSY: begin
          if (mul_done) begin
            state   <= ST_HOLD;
            result  <= mul_prod;
            nzp     <= nzp_of(mul_prod);
            ovf     <= 1'b0;
            illegal <= 1'b0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed table-driven bench for alu_pipe
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic        imm_sel;
  logic [4:0]  imm;
  logic [15:0] ra;
  logic [15:0] rb;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [2:0]  nzp;
  logic        ovf;
  logic        illegal;

  int checks = 0;
  int failures = 0;

  alu_pipe #(.WIDTH(16), .IMM_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .imm_sel   (imm_sel),
    .imm       (imm),
    .ra        (ra),
    .rb        (rb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .nzp       (nzp),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        imm_sel;
    logic [4:0]  imm;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] res;
    logic [2:0]  nzp;
    logic        ovf;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] o, input logic s, input logic [4:0] i,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] r, input logic [2:0] n,
                              input logic v, input logic il);
    vec_t t;
    t.op = o; t.imm_sel = s; t.imm = i; t.ra = a; t.rb = b;
    t.res = r; t.nzp = n; t.ovf = v; t.ill = il;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic s, input logic [4:0] i,
                       input logic [15:0] a, input logic [15:0] b);
    op = o; imm_sel = s; imm = i; ra = a; rb = b;
  endtask

  task automatic check_out(input string tag, input logic [15:0] r, input logic [2:0] n,
                           input logic v, input logic il);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(1'b1));
    chk({tag, ".result"}, 32'(result), 32'(r));
    chk({tag, ".nzp"}, 32'(nzp), 32'(n));
    chk({tag, ".ovf"}, 32'(ovf), 32'(v));
    chk({tag, ".illegal"}, 32'(illegal), 32'(il));
  endtask

  logic [15:0] s_ra[5];
  logic [15:0] s_rb[5];
  logic [15:0] s_res[5];
  logic [2:0]  s_nzp[5];
  logic        s_ovf[5];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(3'b000, 1'b0, 5'd0, 16'h0, 16'h0);

    vecs.push_back(mk(3'b001, 1'b1, 5'b00001, 16'h7FFF, 16'h0000, 16'h8000, 3'b100, 1'b1, 1'b0));
    vecs.push_back(mk(3'b010, 1'b0, 5'b00000, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b001, 1'b0, 1'b0));
    vecs.push_back(mk(3'b011, 1'b0, 5'b00000, 16'hFFFF, 16'h1234, 16'h0000, 3'b010, 1'b0, 1'b0));
    vecs.push_back(mk(3'b000, 1'b0, 5'b00000, 16'h8001, 16'h5555, 16'h8001, 3'b100, 1'b0, 1'b0));
    vecs.push_back(mk(3'b100, 1'b0, 5'b00000, 16'h8000, 16'h0001, 16'h7FFF, 3'b001, 1'b1, 1'b0));
    vecs.push_back(mk(3'b001, 1'b1, 5'b10000, 16'h0010, 16'h0000, 16'h0000, 3'b010, 1'b0, 1'b0));
    vecs.push_back(mk(3'b100, 1'b1, 5'b11111, 16'h0005, 16'h0000, 16'h0006, 3'b001, 1'b0, 1'b0));
    vecs.push_back(mk(3'b001, 1'b0, 5'b11111, 16'h1234, 16'h4321, 16'h5555, 3'b001, 1'b0, 1'b0));
    vecs.push_back(mk(3'b111, 1'b0, 5'b00000, 16'h1234, 16'h0001, 16'h0000, 3'b010, 1'b0, 1'b1));
    vecs.push_back(mk(3'b110, 1'b1, 5'b00111, 16'hFFFF, 16'h0001, 16'h0000, 3'b010, 1'b0, 1'b1));
`ifndef ALU_MUL_EN
    vecs.push_back(mk(3'b101, 1'b0, 5'b00000, 16'h0003, 16'hFFFE, 16'h0000, 3'b010, 1'b0, 1'b1));
`endif

    s_ra[0] = 16'h0100; s_rb[0] = 16'h0001; s_res[0] = 16'h00FF; s_nzp[0] = 3'b001; s_ovf[0] = 1'b0;
    s_ra[1] = 16'h0000; s_rb[1] = 16'h0001; s_res[1] = 16'hFFFF; s_nzp[1] = 3'b100; s_ovf[1] = 1'b0;
    s_ra[2] = 16'h7FFF; s_rb[2] = 16'hFFFF; s_res[2] = 16'h8000; s_nzp[2] = 3'b100; s_ovf[2] = 1'b1;
    s_ra[3] = 16'h1234; s_rb[3] = 16'h1234; s_res[3] = 16'h0000; s_nzp[3] = 3'b010; s_ovf[3] = 1'b0;
    s_ra[4] = 16'h0003; s_rb[4] = 16'h0005; s_res[4] = 16'hFFFE; s_nzp[4] = 3'b100; s_ovf[4] = 1'b0;

    // reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.out_valid", 32'(out_valid), 32'(1'b0));
    chk("rst.in_ready", 32'(in_ready), 32'(1'b1));
    chk("rst.nzp", 32'(nzp), 32'(3'b010));
    chk("rst.result", 32'(result), 32'(16'h0));
    chk("rst.ovf", 32'(ovf), 32'(1'b0));
    chk("rst.illegal", 32'(illegal), 32'(1'b0));

    // table vectors, one at a time with a held cycle before consumption
    foreach (vecs[k]) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      drive(vecs[k].op, vecs[k].imm_sel, vecs[k].imm, vecs[k].ra, vecs[k].rb);
      in_valid = 1'b1; out_ready = 1'b0;
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(1'b1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_out(tag, vecs[k].res, vecs[k].nzp, vecs[k].ovf, vecs[k].ill);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ".drained"}, 32'(out_valid), 32'(1'b0));
    end

    // back-to-back SUB stream, then backpressure
    drive(3'b100, 1'b0, 5'd0, s_ra[0], s_rb[0]);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check_out($sformatf("stream%0d", k), s_res[k], s_nzp[k], s_ovf[k], 1'b0);
      drive(3'b100, 1'b0, 5'd0, s_ra[k+1], s_rb[k+1]);
      if (k == 3) out_ready = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d.in_ready", k), 32'(in_ready), 32'(1'b0));
      @(posedge clk); #1;
      check_out($sformatf("stall%0d", k), s_res[3], s_nzp[3], s_ovf[3], 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall.in_ready", 32'(in_ready), 32'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_out("stream4", s_res[4], s_nzp[4], s_ovf[4], 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stream.drained", 32'(out_valid), 32'(1'b0));

    // reset while a result is held
    drive(3'b001, 1'b0, 5'd0, 16'h0001, 16'h0001);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_out("hold", 16'h0002, 3'b001, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("hold_rst.out_valid", 32'(out_valid), 32'(1'b0));
    chk("hold_rst.result", 32'(result), 32'(16'h0));
    chk("hold_rst.nzp", 32'(nzp), 32'(3'b010));
    chk("hold_rst.in_ready", 32'(in_ready), 32'(1'b1));
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef ALU_MUL_EN
    begin
      int cyc;
      drive(3'b101, 1'b0, 5'd0, 16'h0003, 16'hFFFE);
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 0;
      chk("mul.busy_in_ready", 32'(in_ready), 32'(1'b0));
      while (!out_valid && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("mul.latency", 32'(cyc), 32'd16);
      check_out("mul", 16'hFFFA, 3'b100, 1'b0, 1'b0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      drive(3'b101, 1'b0, 5'd0, 16'h0003, 16'hFFFE);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mul_rst.out_valid", 32'(out_valid), 32'(1'b0));
      chk("mul_rst.in_ready", 32'(in_ready), 32'(1'b1));
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("mul_rst.quiet", 32'(out_valid), 32'(1'b0));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the LC-3 datapath ALU. Accepts one operation per transaction on a valid/ready input channel, selects the second operand from a register value or a sign-extended immediate, and returns a registered result with NZP condition codes and a signed-overflow flag on a valid/ready output channel. Single-cycle ops have one cycle of latency. An optional iterative shift-add multiplier adds a multi-cycle op. Sits between register-file read and the writeback/CC-update stage of the LC-3 core.

## Interface
- WIDTH, 16: datapath width in bits (>= 4).
- IMM_W, 5: immediate field width in bits (< WIDTH).
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block accepts request this cycle.
- op  input  3  operation: 000 PASSA, 001 ADD, 010 AND, 011 NOT, 100 SUB, 101 MUL; 110/111 reserved.
- imm_sel  input  1  1 = operand B is the sign-extended imm; 0 = rb.
- imm  input  IMM_W  immediate, sign-extended from its bit IMM_W-1.
- ra, rb  input  WIDTH  operands.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- nzp  output  3  {N,Z,P} of result; exactly one bit set while out_valid.
- ovf  output  1  signed overflow for ADD/SUB; 0 for all other ops.
- illegal  output  1  reserved op, or MUL when compiled out.

## Operation
- B = imm_sel ? sext(imm) : rb. B is captured at accept time.
- PASSA: ra. ADD: ra+B mod 2^WIDTH. AND: ra&B. NOT: ~ra, with B ignored. SUB: ra-B mod 2^WIDTH. MUL: low WIDTH bits of ra*B, treated as unsigned; two's-complement low bits are therefore correct.
- ovf (ADD): operand signs are equal and the result sign differs. ovf (SUB): ra and B signs differ and the result sign differs from ra.
- Illegal op: result=0, nzp=010, ovf=0, illegal=1. Latency is one cycle.
- FSM states:
  - IDLE (no result held).
  - BUSY (MUL iterating).
  - HOLD (result held, out_valid=1).
- Transitions:
  - IDLE + accept of a non-MUL op -> HOLD.
  - IDLE + accept of MUL -> BUSY.
  - BUSY + counter reaches 0 -> HOLD.
  - HOLD + out_ready with no new accept -> IDLE.
  - HOLD + out_ready with a new accept -> HOLD for a non-MUL op, or BUSY for MUL.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). It is combinational from state and out_ready, and never depends on in_valid.
- out_valid = (state==HOLD). result, nzp, ovf and illegal are stable while out_valid=1 and out_ready=0.
- Multiplier: captures multiplicand, multiplier and a log2(WIDTH)+1-bit counter loaded with WIDTH. Each BUSY cycle conditionally adds the multiplicand, shifts the multiplicand left and the multiplier right, and decrements the counter.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, out_valid=0, result=0, nzp=010, ovf=0, illegal=0, counter=0. in_ready=1 from the first cycle after reset.
- Non-MUL op accepted at edge N: out_valid=1 after edge N; result is visible in cycle N+1.
- MUL accepted at edge N: out_valid=1 after edge N+WIDTH. in_ready=0 throughout BUSY.
- Back-to-back throughput for non-MUL ops is 1 per cycle when out_ready is held high.
- Reset asserted mid-BUSY or mid-HOLD: the operation and the held result are discarded and the block returns to IDLE immediately.
- in_valid with in_ready=0: no state change. The requester must hold its inputs stable.

## Configuration
- ALU_MUL_EN defined: the MUL op, the BUSY state and the multiplier datapath are built.
- ALU_MUL_EN undefined: op 101 is treated as illegal with one-cycle latency, and the BUSY state and multiplier registers are absent.

## Structure
- Package alu_pipe_pkg holds:
  - the op enum: ALU_PASSA, ALU_ADD, ALU_AND, ALU_NOT, ALU_SUB, ALU_MUL;
  - the state enum: ST_IDLE, ST_BUSY, ST_HOLD;
  - the NZP encoding constants: NZP_N=100, NZP_Z=010, NZP_P=001.
- One sub-module, alu_pipe_mul: the iterative shift-add engine, with start, done, a, b and prod ports. It is instantiated only under ALU_MUL_EN.
- The combinational op mux and the flag logic stay in the top.

## Test plan
- Reset check: hold rst_n low, then release. Required: out_valid=0, in_ready=1, nzp=010, result=0.
- WIDTH=16, ADD with ra=0x7FFF, imm_sel=1, imm=5'b00001. Required: result=0x8000, nzp=100, ovf=1, out_valid one cycle after accept.
- AND with ra=0xF0F0, imm_sel=0, rb=0x0FF0. Required: result=0x00F0, nzp=001. Then NOT with ra=0xFFFF. Required: result=0x0000, nzp=010.
- Stream of 4 SUB ops with out_ready=1 throughout. Required: 4 results on 4 consecutive cycles. Then hold out_ready=0 for 3 cycles. Required: result stable and in_ready=0 until out_ready rises.
- MUL (ALU_MUL_EN), ra=0x0003, rb=0xFFFE. Required: result=0xFFFA, nzp=100, out_valid exactly 16 cycles after accept. Pulse rst_n low during a repeat MUL. Required: IDLE and out_valid=0 immediately.
- op=3'b111, and op=MUL with ALU_MUL_EN undefined. Required: illegal=1, result=0, nzp=010, one-cycle latency.
